// File: rtl/fir_stream_param.sv
// Streaming direct-form FIR with coefficient shift-load, valid/ready sample handshake and registered output.
// Optional output saturation is enabled by defining FIR_SAT_EN; otherwise the output wraps.
module fir_stream_param #(
  parameter int NTAPS     = 4,
  parameter int XW        = 8,
  parameter int CW        = 6,
  parameter int YW        = 12,
  parameter int OUT_SHIFT = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [XW-1:0] x_n,
  input  logic          x_valid,
  output logic          x_ready,
  input  logic          coef_load,
  output logic [YW-1:0] y_n,
  output logic          y_valid,
  output logic          busy
);

  localparam int ACCW = XW + CW + $clog2(NTAPS);
  localparam int SW   = (ACCW > YW) ? ACCW : YW;
  localparam int CNTW = $clog2(NTAPS);

  localparam logic signed [SW-1:0] Y_MAX = (SW'(1) <<< (YW - 1)) - SW'(1);
  localparam logic signed [SW-1:0] Y_MIN = ~Y_MAX;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_RUN  = 2'd2,
    ST_LOAD = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [CNTW-1:0]       cnt_q, cnt_d;
  logic signed [CW-1:0]  c_q [NTAPS];
  logic signed [CW-1:0]  c_d [NTAPS];
  logic signed [XW-1:0]  d_q [NTAPS];
  logic signed [XW-1:0]  d_d [NTAPS];
  logic signed [XW-1:0]  d_new [NTAPS];
  logic [YW-1:0]         y_n_q, y_n_d;
  logic                  y_valid_q, y_valid_d;
  logic                  x_ready_q, x_ready_d;
  logic                  busy_q, busy_d;
  logic                  accept;
  logic                  enter_load;
  logic signed [ACCW-1:0] acc;
  logic signed [SW-1:0]   acc_sh;

  // Reduce the shifted accumulator to the output width (clamp or wrap).
  function automatic logic [YW-1:0] reduce_acc(input logic signed [SW-1:0] v);
`ifdef FIR_SAT_EN
    if (v > Y_MAX) begin
      return Y_MAX[YW-1:0];
    end else if (v < Y_MIN) begin
      return Y_MIN[YW-1:0];
    end else begin
      return v[YW-1:0];
    end
`else
    return v[YW-1:0];
`endif
  endfunction

  // Delay line as it would look with this cycle's sample shifted in, and the MAC over it.
  always_comb begin
    acc = '0;
    d_new[0] = x_n;
    for (int k = 1; k < NTAPS; k++) begin
      d_new[k] = d_q[k-1];
    end
    for (int k = 0; k < NTAPS; k++) begin
      acc = acc + ACCW'(c_q[k]) * ACCW'(d_new[k]);
    end
    acc_sh = SW'(acc) >>> OUT_SHIFT;
  end

  // Next-state logic for the control FSM.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_INIT: begin
        if (cnt_q == CNTW'(NTAPS - 1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end
      ST_IDLE: begin
        if (coef_load) begin
          state_d = ST_LOAD;
        end else if (x_valid) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (coef_load) begin
          state_d = ST_LOAD;
        end else if (!x_valid) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_LOAD: begin
        if (coef_load) begin
          state_d = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = '0;
      end
    endcase
  end

  // Datapath next values: sample acceptance, coefficient shift and output stage.
  always_comb begin
    c_d        = c_q;
    d_d        = d_q;
    y_n_d      = y_n_q;
    y_valid_d  = 1'b0;
    accept     = ((state_q == ST_IDLE) || (state_q == ST_RUN)) && x_valid && !coef_load;
    enter_load = (state_d == ST_LOAD) && (state_q != ST_LOAD);
    x_ready_d  = (state_d == ST_IDLE) || (state_d == ST_RUN);
    busy_d     = (state_d == ST_INIT) || (state_d == ST_LOAD);

    if (accept) begin
      d_d       = d_new;
      y_n_d     = reduce_acc(acc_sh);
      y_valid_d = 1'b1;
    end else if (enter_load) begin
      // Stale history would mix old samples with new coefficients, so it is flushed.
      for (int k = 0; k < NTAPS; k++) begin
        d_d[k] = '0;
      end
      y_n_d = '0;
    end else begin
      y_valid_d = 1'b0;
    end

    // The request cycle that enters LOAD writes nothing; only cycles already in LOAD shift.
    if ((state_q == ST_LOAD) && coef_load) begin
      c_d[0] = x_n[CW-1:0];
      for (int k = 1; k < NTAPS; k++) begin
        c_d[k] = c_q[k-1];
      end
    end else begin
      c_d = c_q;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_INIT;
      cnt_q     <= '0;
      y_n_q     <= '0;
      y_valid_q <= 1'b0;
      x_ready_q <= 1'b0;
      busy_q    <= 1'b1;
      for (int k = 0; k < NTAPS; k++) begin
        c_q[k] <= '0;
        d_q[k] <= '0;
      end
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      y_n_q     <= y_n_d;
      y_valid_q <= y_valid_d;
      x_ready_q <= x_ready_d;
      busy_q    <= busy_d;
      for (int k = 0; k < NTAPS; k++) begin
        c_q[k] <= c_d[k];
        d_q[k] <= d_d[k];
      end
    end
  end

  assign y_n     = y_n_q;
  assign y_valid = y_valid_q;
  assign x_ready = x_ready_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_fir_stream_param.sv
// Directed, table-driven bench for fir_stream_param (NTAPS=4, XW=8, CW=6, YW=12, OUT_SHIFT=0).
// Expected values follow the FIR_SAT_EN setting of the build.
module tb_fir_stream_param;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  x_n;
  logic        x_valid;
  logic        x_ready;
  logic        coef_load;
  logic [11:0] y_n;
  logic        y_valid;
  logic        busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        xv;
    logic        cl;
    logic [7:0]  x;
    logic        ev;
    logic [11:0] ey;
    logic        er;
    logic        eb;
  } vec_t;

  vec_t        vecs[$];
  logic [11:0] e3 [4];
  logic [11:0] e4 [4];

  fir_stream_param #(
    .NTAPS(4), .XW(8), .CW(6), .YW(12), .OUT_SHIFT(0)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .x_n       (x_n),
    .x_valid   (x_valid),
    .x_ready   (x_ready),
    .coef_load (coef_load),
    .y_n       (y_n),
    .y_valid   (y_valid),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic xv, input logic cl, input logic [7:0] x);
    x_valid   = xv;
    coef_load = cl;
    x_n       = x;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic xv, input logic cl, input logic [7:0] x,
                     input logic ev, input logic [11:0] ey, input logic er, input logic eb);
    vec_t v;
    v.xv = xv; v.cl = cl; v.x = x; v.ev = ev; v.ey = ey; v.er = er; v.eb = eb;
    vecs.push_back(v);
  endtask

  task automatic chk_outs(input string tag, input logic ev, input logic [11:0] ey,
                          input logic er, input logic eb);
    chk({tag, " y_valid"}, 32'(y_valid), 32'(ev));
    chk({tag, " y_n"},     32'(y_n),     32'(ey));
    chk({tag, " x_ready"}, 32'(x_ready), 32'(er));
    chk({tag, " busy"},    32'(busy),    32'(eb));
  endtask

  initial begin
    int n;
`ifdef FIR_SAT_EN
    e3 = '{12'h7FF, 12'h7FF, 12'h7FF, 12'h7FF};
    e4 = '{12'h800, 12'h800, 12'h800, 12'h800};
`else
    e3 = '{12'hF61, 12'hEC2, 12'hE23, 12'hD84};
    e4 = '{12'h020, 12'h040, 12'h060, 12'h080};
`endif

    // coefficient load 4,3,2,1 then impulse with a one-cycle gap
    add(1'b0, 1'b1, 8'h00, 1'b0, 12'h000, 1'b0, 1'b1);
    add(1'b0, 1'b1, 8'h04, 1'b0, 12'h000, 1'b0, 1'b1);
    add(1'b0, 1'b1, 8'h03, 1'b0, 12'h000, 1'b0, 1'b1);
    add(1'b0, 1'b1, 8'h02, 1'b0, 12'h000, 1'b0, 1'b1);
    add(1'b0, 1'b1, 8'h01, 1'b0, 12'h000, 1'b0, 1'b1);
    add(1'b0, 1'b0, 8'h00, 1'b0, 12'h000, 1'b1, 1'b0);
    add(1'b1, 1'b0, 8'h01, 1'b1, 12'h001, 1'b1, 1'b0);
    add(1'b1, 1'b0, 8'h00, 1'b1, 12'h002, 1'b1, 1'b0);
    add(1'b0, 1'b0, 8'h00, 1'b0, 12'h002, 1'b1, 1'b0);
    add(1'b1, 1'b0, 8'h00, 1'b1, 12'h003, 1'b1, 1'b0);
    add(1'b1, 1'b0, 8'h00, 1'b1, 12'h004, 1'b1, 1'b0);
    add(1'b1, 1'b0, 8'h00, 1'b1, 12'h000, 1'b1, 1'b0);
    // all coefficients 31, x=127 x4
    add(1'b0, 1'b1, 8'h00, 1'b0, 12'h000, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) add(1'b0, 1'b1, 8'h1F, 1'b0, 12'h000, 1'b0, 1'b1);
    add(1'b0, 1'b0, 8'h00, 1'b0, 12'h000, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) add(1'b1, 1'b0, 8'h7F, 1'b1, e3[i], 1'b1, 1'b0);
    // entering LOAD clears a nonzero y_n; all coefficients -32, x=127 x4
    add(1'b0, 1'b1, 8'h00, 1'b0, 12'h000, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) add(1'b0, 1'b1, 8'h20, 1'b0, 12'h000, 1'b0, 1'b1);
    add(1'b0, 1'b0, 8'h00, 1'b0, 12'h000, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) add(1'b1, 1'b0, 8'h7F, 1'b1, e4[i], 1'b1, 1'b0);
    // coef_load beats x_valid in RUN; the flushed delay line leaves only the new impulse
    add(1'b1, 1'b1, 8'h7F, 1'b0, 12'h000, 1'b0, 1'b1);
    add(1'b0, 1'b0, 8'h00, 1'b0, 12'h000, 1'b1, 1'b0);
    add(1'b1, 1'b0, 8'h01, 1'b1, 12'hFE0, 1'b1, 1'b0);
    add(1'b1, 1'b0, 8'h00, 1'b1, 12'hFE0, 1'b1, 1'b0);

    // reset for two cycles, then four INIT cycles
    reset = 1'b1;
    x_valid = 1'b0; coef_load = 1'b0; x_n = 8'h00;
    @(posedge clk); #1;
    chk_outs("reset1", 1'b0, 12'h000, 1'b0, 1'b1);
    @(posedge clk); #1;
    chk_outs("reset2", 1'b0, 12'h000, 1'b0, 1'b1);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk_outs($sformatf("init%0d", i), 1'b0, 12'h000, 1'b0, 1'b1);
      step(1'b1, 1'b0, 8'h05);
    end
    chk_outs("idle", 1'b0, 12'h000, 1'b1, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].xv, vecs[i].cl, vecs[i].x);
      chk_outs($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ey, vecs[i].er, vecs[i].eb);
    end

    // reset in LOAD after two words wipes the coefficients
    step(1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b1, 8'h05);
    step(1'b0, 1'b1, 8'h07);
    reset = 1'b1;
    step(1'b1, 1'b0, 8'h01);
    chk_outs("rst_load", 1'b0, 12'h000, 1'b0, 1'b1);
    reset = 1'b0;
    n = 0;
    while (!x_ready && n < 20) begin
      step(1'b0, 1'b0, 8'h00);
      n++;
    end
    chk("rst_init_len", 32'(n), 32'd4);
    chk("rst_init_exit", 32'(x_ready), 32'd1);
    step(1'b1, 1'b0, 8'h01);
    chk_outs("rst_imp0", 1'b1, 12'h000, 1'b1, 1'b0);
    for (int i = 1; i < 4; i++) begin
      step(1'b1, 1'b0, 8'h00);
      chk_outs($sformatf("rst_imp%0d", i), 1'b1, 12'h000, 1'b1, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
